// File: rtl/regfile_dump_reader.sv
// Walks the register file debug port from FIRST_REG to LAST_REG and streams header, {idx, 4 data bytes} per register, XOR checksum.
// Registered outputs; each byte is held until tx_valid && tx_ready, and one dead cycle per register captures data_dbg.
module regfile_dump_reader #(
  parameter int          FIRST_REG   = 0,
  parameter int          LAST_REG    = 31,
  parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [4:0]  req_dbg,
  input  logic [31:0] data_dbg,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] FIRST_IDX = FIRST_REG[4:0];
  localparam logic [4:0] LAST_IDX  = LAST_REG[4:0];

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] HDR    = 4'd1;
  localparam logic [3:0] LOAD   = 4'd2;
  localparam logic [3:0] S_IDX  = 4'd3;
  localparam logic [3:0] S_D3   = 4'd4;
  localparam logic [3:0] S_D2   = 4'd5;
  localparam logic [3:0] S_D1   = 4'd6;
  localparam logic [3:0] S_D0   = 4'd7;
  localparam logic [3:0] S_CSUM = 4'd8;

  logic [3:0]  state;
  logic [4:0]  idx;
  logic [31:0] word;
  logic [7:0]  csum;
  logic        accept;

  assign accept  = tx_valid && tx_ready;
  assign req_dbg = idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= FIRST_IDX;
      word     <= 32'd0;
      csum     <= 8'd0;
      tx_valid <= 1'b0;
      tx_data  <= 8'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx      <= FIRST_IDX;
            csum     <= 8'd0;
            busy     <= 1'b1;
            tx_valid <= 1'b1;
            tx_data  <= HEADER_BYTE;
            state    <= HDR;
          end
        end
        HDR: begin
          // Header is deliberately left out of the checksum.
          if (accept) begin
            tx_valid <= 1'b0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          word     <= data_dbg;
          tx_valid <= 1'b1;
          tx_data  <= {3'b000, idx};
          state    <= S_IDX;
        end
        S_IDX: begin
          if (accept) begin
            csum    <= csum ^ tx_data;
            tx_data <= word[31:24];
            state   <= S_D3;
          end
        end
        S_D3: begin
          if (accept) begin
            csum    <= csum ^ tx_data;
            tx_data <= word[23:16];
            state   <= S_D2;
          end
        end
        S_D2: begin
          if (accept) begin
            csum    <= csum ^ tx_data;
            tx_data <= word[15:8];
            state   <= S_D1;
          end
        end
        S_D1: begin
          if (accept) begin
            csum    <= csum ^ tx_data;
            tx_data <= word[7:0];
            state   <= S_D0;
          end
        end
        S_D0: begin
          if (accept) begin
            csum <= csum ^ tx_data;
            if (idx == LAST_IDX) begin
              // Checksum byte must include the data byte accepted this cycle.
              tx_data <= csum ^ tx_data;
              state   <= S_CSUM;
            end else begin
              idx      <= idx + 5'd1;
              tx_valid <= 1'b0;
              state    <= LOAD;
            end
          end
        end
        S_CSUM: begin
          if (accept) begin
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          tx_valid <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomised bench for regfile_dump_reader against a frame-level reference model.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  req_dbg;
  logic [31:0] data_dbg;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        busy;
  logic        done;

  logic        start2 = 1'b0;
  logic [4:0]  req2;
  logic [31:0] data2;
  logic [7:0]  txd2;
  logic        txv2;
  logic        txr2 = 1'b1;
  logic        busy2;
  logic        done2;

  logic [31:0] regs [0:31];
  logic [7:0]  got_q [$];
  logic [7:0]  exp_q [$];
  int          busy_cnt;
  int          done_cnt;
  int          checks = 0;
  int          errors = 0;

  assign data_dbg = regs[req_dbg];
  assign data2    = regs[req2];

  always #5 clk = ~clk;

  regfile_dump_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .req_dbg(req_dbg), .data_dbg(data_dbg),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
  );

  regfile_dump_reader #(.FIRST_REG(5), .LAST_REG(5), .HEADER_BYTE(8'hA5)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .req_dbg(req2), .data_dbg(data2),
    .tx_data(txd2), .tx_valid(txv2), .tx_ready(txr2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected frame straight from the framing rules over the current register contents.
  task automatic build_exp(input int first, input int last);
    logic [7:0] cs;
    logic [7:0] b;
    logic [31:0] w;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    cs = 8'h00;
    for (int i = first; i <= last; i++) begin
      b = 8'(i);
      exp_q.push_back(b);
      cs ^= b;
      w = regs[i];
      for (int k = 3; k >= 0; k--) begin
        b = w[8*k +: 8];
        exp_q.push_back(b);
        cs ^= b;
      end
    end
    exp_q.push_back(cs);
  endtask

  task automatic compare_frame(input string tag, input int first, input int last, input int busy_exp);
    int nbad;
    build_exp(first, last);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    nbad = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) nbad++;
    chk({tag, "_bytes"}, nbad, 0);
    chk({tag, "_done"}, done_cnt, 1);
    if (busy_exp >= 0) chk({tag, "_busy"}, busy_cnt, busy_exp);
  endtask

  // Drives/observes one frame on dut; restart holds start high from cycle 40 through the done cycle.
  task automatic dump(input int rdy_pct, input bit pulse, input bit restart, input bit wr3);
    logic       stalled;
    logic [7:0] prev_data;
    got_q.delete();
    busy_cnt = 0;
    done_cnt = 0;
    stalled = 1'b0;
    prev_data = 8'h00;
    if (pulse) begin
      @(negedge clk);
      start = 1'b1;
    end
    for (int cyc = 0; ; cyc++) begin
      @(negedge clk);
      if (cyc >= 3000) begin
        chk("timeout", 1, 0);
        break;
      end
      start = restart && cyc >= 40;
      if (done) begin
        done_cnt++;
        chk("busy_at_done", busy, 0);
        break;
      end
      if (busy) busy_cnt++;
      if (stalled) begin
        chk("stall_valid", tx_valid, 1);
        chk("stall_data", tx_data, prev_data);
      end
      if (wr3 && busy && !tx_valid && req_dbg == 5'd3) regs[3] = 32'hCAFEF00D;
      tx_ready = ($urandom_range(99) < rdy_pct);
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      stalled = tx_valid && !tx_ready;
      prev_data = tx_data;
    end
  endtask

  task automatic load_pattern();
    for (int i = 0; i < 32; i++) regs[i] = 32'h01010101 * i;
  endtask

  initial begin
    int n;
    bit hit;
    load_pattern();

    #12;
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", req_dbg, 0);
    chk("rst_req2", req2, 5);
    @(negedge clk);
    rst_n = 1'b1;

    dump(100, 1'b1, 1'b0, 1'b0);
    compare_frame("pattern", 0, 31, 194);
    chk("pattern_last_byte0", got_q[1], 8'h00);
    @(negedge clk);
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);

    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    dump(50, 1'b1, 1'b0, 1'b0);
    compare_frame("rand_ready", 0, 31, -1);

    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    dump(60, 1'b1, 1'b1, 1'b0);
    compare_frame("restart_held", 0, 31, -1);
    dump(100, 1'b0, 1'b0, 1'b0);
    compare_frame("second_frame", 0, 31, 194);

    load_pattern();
    dump(100, 1'b1, 1'b0, 1'b1);
    chk("wr3_applied", regs[3], 32'hCAFEF00D);
    compare_frame("late_write", 0, 31, 194);

    load_pattern();
    @(negedge clk);
    start = 1'b1;
    tx_ready = 1'b1;
    n = 0;
    hit = 1'b0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (tx_valid && n == 38) begin
        hit = 1'b1;
        break;
      end
      if (tx_valid) n++;
    end
    chk("rst_reach_d2", hit, 1);
    chk("rst_pre_d2_data", tx_data, 8'h07);
    chk("rst_pre_req", req_dbg, 7);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", tx_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_req", req_dbg, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dump(100, 1'b1, 1'b0, 1'b0);
    compare_frame("after_abort", 0, 31, 194);

    regs[5] = 32'hDEADBEEF;
    got_q.delete();
    busy_cnt = 0;
    done_cnt = 0;
    @(negedge clk);
    start2 = 1'b1;
    for (int cyc = 0; ; cyc++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (cyc >= 100) begin
        chk("single_timeout", 1, 0);
        break;
      end
      if (done2) begin
        done_cnt++;
        break;
      end
      if (busy2) busy_cnt++;
      if (txv2 && txr2) got_q.push_back(txd2);
    end
    compare_frame("single_reg", 5, 5, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
